// File: rtl/cpu_pio_in_edge.sv
// Edge-capturing parallel input port with an Avalon-MM slave and a level IRQ.
// Ports: clk, reset (sync, active-high), address/chipselect/write_n/writedata,
//        readdata (latency 1), in_port (async inputs), irq (active-high level).
module cpu_pio_in_edge #(
  parameter int WIDTH       = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] PRIME = CW'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] edges_ok;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] wdata;
  logic [CW-1:0]    prime_cnt;
  logic             armed;
  logic             wr;
  logic [31:0]      rd_next;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;
  assign wdata = writedata[WIDTH-1:0];
  assign wr = chipselect & ~write_n;

  // Synchroniser chain; the last stage is the only
  // value the rest of the block ever looks at.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign data_in = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) prev <= '0;
    else       prev <= data_in;
  end

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edges = data_in & ~prev;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edges = ~data_in & prev;
    end else begin : g_any
      assign edges = data_in ^ prev;
    end
  endgenerate

  // After reset the chain and prev are zero, so an input
  // already high would look like a rising edge while it
  // propagates. Detection stays off until the chain has
  // filled and prev has caught up with it.
  always_ff @(posedge clk) begin
    if (reset)
      prime_cnt <= PRIME;
    else if (prime_cnt != '0)
      prime_cnt <= prime_cnt - CW'(1);
  end

  assign armed    = (prime_cnt == '0);
  assign edges_ok = edges & {WIDTH{armed}};

  always_ff @(posedge clk) begin
    if (reset)
      mask <= '0;
    else if (wr && address == 2'd2)
      mask <= wdata;
  end

  assign clr = (wr && address == 2'd3) ? wdata : '0;

  // A new edge overrides a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) capture <= '0;
    else       capture <= (capture & ~clr) | edges_ok;
  end

  always_comb begin
    rd_next = '0;
    unique case (address)
      2'd0: rd_next = 32'(data_in);
      2'd1: rd_next = '0;
      2'd2: rd_next = 32'(mask);
      2'd3: rd_next = 32'(capture);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_next;
  end

  assign irq = |(capture & mask);

endmodule
